// File: rtl/softmax_pkg.sv
// Shared types and defaults for the softmax row datapath.
package softmax_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ROW_LEN = 32;

    typedef logic signed [DEF_DATA_W-1:0] elem_t;
    typedef elem_t row_t [DEF_ROW_LEN];

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        HOLD
    } fetch_state_t;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// Delay line of {valid, col} tags that follows BRAM read latency, so each
// returning data word emerges together with the row slot it belongs to.
module bram_rd_tag_pipe #(
    parameter int RD_LAT = 1,
    parameter int COL_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    input  logic [COL_W-1:0] push_col,
    output logic             pop_valid,
    output logic [COL_W-1:0] pop_col
);

    logic [RD_LAT-1:0] vld_sr;
    logic [COL_W-1:0]  col_sr [RD_LAT];

    // Shift tags one stage per cycle; reset drops every in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                col_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= push_valid;
            col_sr[0] <= push_col;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                col_sr[i] <= col_sr[i-1];
            end
        end
    end

    assign pop_valid = vld_sr[RD_LAT-1];
    assign pop_col   = col_sr[RD_LAT-1];

endmodule

// File: rtl/bram_row_fetcher.sv
// Reads bursts of consecutive rows out of a row-major BRAM and presents each
// row in parallel to the softmax engine behind a valid/ready handshake.
module bram_row_fetcher
    import softmax_pkg::*;
#(
    parameter int  DATA_W   = softmax_pkg::DEF_DATA_W,
    parameter int  ROW_LEN  = softmax_pkg::DEF_ROW_LEN,
    parameter int  NUM_ROWS = 32,
    parameter int  RD_LAT   = 1,
    localparam int ADDR_W   = $clog2(NUM_ROWS * ROW_LEN),
    localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [ROW_W-1:0]         i_row_idx,
    input  logic [ROW_W:0]           i_num_rows,
    output logic                     o_busy,
    output logic                     o_err,
    output logic                     o_bram_en,
    output logic [ADDR_W-1:0]        o_bram_addr,
    input  logic signed [DATA_W-1:0] i_bram_data,
    output logic signed [DATA_W-1:0] o_row [ROW_LEN],
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_done
);

    localparam int               COL_W    = $clog2(ROW_LEN);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_LEN - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);
    localparam logic [ROW_W:0]   MAX_NUM  = (ROW_W + 1)'(NUM_ROWS);

    fetch_state_t     state;
    logic [ROW_W-1:0] cur_row;
    logic [ROW_W:0]   rows_left;
    logic [COL_W-1:0] col;

    logic             tag_valid;
    logic [COL_W-1:0] tag_col;
    logic             row_ok;
    logic             num_ok;
    logic             start_ok;

    // When NUM_ROWS fills the index width every encodable row exists, so the
    // range check collapses to a constant instead of a tautological compare.
    generate
        if (NUM_ROWS == (1 << ROW_W)) begin : g_row_full
            assign row_ok = 1'b1;
        end else begin : g_row_cmp
            assign row_ok = (i_row_idx < LAST_ROW) || (i_row_idx == LAST_ROW);
        end
    endgenerate

    assign num_ok   = (i_num_rows != '0) && (i_num_rows <= MAX_NUM);
    assign start_ok = row_ok && num_ok;

    assign o_bram_en   = (state == ISSUE);
    assign o_bram_addr = (state == ISSUE)
                       ? (ADDR_W'(cur_row) * ADDR_W'(ROW_LEN) + ADDR_W'(col))
                       : '0;

    bram_rd_tag_pipe #(
        .RD_LAT (RD_LAT),
        .COL_W  (COL_W)
    ) u_tag_pipe (
        .clk        (i_clk),
        .rst        (i_rst),
        .push_valid (o_bram_en),
        .push_col   (col),
        .pop_valid  (tag_valid),
        .pop_col    (tag_col)
    );

    // Fetch FSM: issue one row of reads, drain the pipe, hold the row until accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            cur_row   <= '0;
            rows_left <= '0;
            col       <= '0;
            o_busy    <= 1'b0;
            o_err     <= 1'b0;
            o_valid   <= 1'b0;
            o_done    <= 1'b0;
            for (int k = 0; k < ROW_LEN; k++) begin
                o_row[k] <= '0;
            end
        end else begin
            o_err  <= 1'b0;
            o_done <= 1'b0;

            if (tag_valid) begin
                o_row[tag_col] <= i_bram_data;
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        if (start_ok) begin
                            cur_row   <= i_row_idx;
                            rows_left <= i_num_rows;
                            col       <= '0;
                            o_busy    <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (col == LAST_COL) begin
                        col   <= '0;
                        state <= DRAIN;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                DRAIN: begin
                    if (tag_valid && (tag_col == LAST_COL)) begin
                        o_valid <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (o_valid && i_ready) begin
                        o_valid   <= 1'b0;
                        rows_left <= rows_left - 1'b1;
                        cur_row   <= (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
                        if (rows_left == (ROW_W + 1)'(1)) begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            col   <= '0;
                            state <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_row_fetcher.sv
// Directed bench for bram_row_fetcher: a latency-1 instance for the main
// scenarios and a latency-2 instance for the slower BRAM configuration.
module tb_bram_row_fetcher;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    logic              i_start = 1'b0;
    logic [4:0]        i_row_idx = '0;
    logic [5:0]        i_num_rows = '0;
    logic              o_busy, o_err, o_bram_en, o_valid, o_done;
    logic              i_ready = 1'b0;
    logic [9:0]        o_bram_addr;
    logic signed [15:0] i_bram_data;
    logic signed [15:0] o_row [32];

    logic              i2_start = 1'b0;
    logic [4:0]        i2_row_idx = '0;
    logic [5:0]        i2_num_rows = '0;
    logic              o2_busy, o2_err, o2_bram_en, o2_valid, o2_done;
    logic              i2_ready = 1'b1;
    logic [9:0]        o2_bram_addr;
    logic signed [15:0] i2_bram_data;
    logic signed [15:0] o2_row [32];

    logic signed [15:0] bram_q1, bram_q2a, bram_q2b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 i_clk = ~i_clk;

    bram_row_fetcher #(.RD_LAT(1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_row_idx(i_row_idx),
        .i_num_rows(i_num_rows), .o_busy(o_busy), .o_err(o_err), .o_bram_en(o_bram_en),
        .o_bram_addr(o_bram_addr), .i_bram_data(i_bram_data), .o_row(o_row),
        .o_valid(o_valid), .i_ready(i_ready), .o_done(o_done)
    );

    bram_row_fetcher #(.RD_LAT(2)) dut2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i2_start), .i_row_idx(i2_row_idx),
        .i_num_rows(i2_num_rows), .o_busy(o2_busy), .o_err(o2_err), .o_bram_en(o2_bram_en),
        .o_bram_addr(o2_bram_addr), .i_bram_data(i2_bram_data), .o_row(o2_row),
        .o_valid(o2_valid), .i_ready(i2_ready), .o_done(o2_done)
    );

    // BRAM models: word at address a holds a-512, one and two cycle latency.
    always @(posedge i_clk) begin
        if (o_bram_en) bram_q1 <= 16'(int'(o_bram_addr) - 512);
        if (o2_bram_en) bram_q2a <= 16'(int'(o2_bram_addr) - 512);
        bram_q2b <= bram_q2a;
    end
    assign i_bram_data  = bram_q1;
    assign i2_bram_data = bram_q2b;

    function automatic logic signed [15:0] exp_elem(input int row, input int k);
        return 16'(row * 32 + k - 512);
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic start_fetch(input int row, input int num);
        i_start = 1'b1;
        i_row_idx = 5'(row);
        i_num_rows = 6'(num);
        cyc = 0;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_valid();
        while (!o_valid && cyc < 200) tick();
    endtask

    task automatic test_reset();
        int bad;
        i_rst = 1'b1;
        tick();
        tick();
        bad = 0;
        for (int k = 0; k < 32; k++) if (o_row[k] !== 16'sd0) bad++;
        checks++;
        if ({o_busy, o_err, o_valid, o_done, o_bram_en} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got busy/err/valid/done/en=%b want 00000",
                     {o_busy, o_err, o_valid, o_done, o_bram_en});
        end
        checks++;
        if (o_bram_addr !== 10'd0 || bad != 0) begin
            failures++;
            $display("[TB] FAIL reset_data: addr=%0d nonzero_elems=%0d want 0 and 0", o_bram_addr, bad);
        end
        checks++;
        if ({o2_busy, o2_err, o2_valid, o2_done} !== 4'b0) begin
            failures++;
            $display("[TB] FAIL reset_lat2: got %b want 0000", {o2_busy, o2_err, o2_valid, o2_done});
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_single_row();
        int bad;
        i_ready = 1'b1;
        start_fetch(3, 1);
        checks++;
        if (o_bram_en !== 1'b1 || o_bram_addr !== 10'd96 || o_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_addr: en=%b addr=%0d busy=%b want 1 96 1", o_bram_en, o_bram_addr, o_busy);
        end
        wait_valid();
        checks++;
        if (cyc != 34) begin
            failures++;
            $display("[TB] FAIL valid_cycle: got %0d want 34", cyc);
        end
        checks++;
        if (o_row[0] !== -16'sd416 || o_row[31] !== -16'sd385) begin
            failures++;
            $display("[TB] FAIL row3_ends: got %0d %0d want -416 -385", o_row[0], o_row[31]);
        end
        bad = 0;
        for (int k = 0; k < 32; k++) if (o_row[k] !== exp_elem(3, k)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL row3_all: %0d wrong elements, want 0", bad);
        end
        tick();
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0 || cyc != 35) begin
            failures++;
            $display("[TB] FAIL done_cycle: done=%b busy=%b valid=%b cyc=%0d want 1 0 0 35",
                     o_done, o_busy, o_valid, cyc);
        end
        tick();
        checks++;
        if (o_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL done_pulse: got %b want 0", o_done);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        i_ready = 1'b0;
        start_fetch(3, 1);
        wait_valid();
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_valid !== 1'b1 || o_done !== 1'b0 || o_busy !== 1'b1) bad++;
            for (int k = 0; k < 32; k++) if (o_row[k] !== exp_elem(3, k)) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL hold_stable: %0d deviations during backpressure, want 0", bad);
        end
        i_ready = 1'b1;
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bp_handshake: valid=%b done=%b want 0 1", o_valid, o_done);
        end
        i_ready = 1'b0;
        tick();
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_after: done=%b busy=%b want 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_wrap_burst();
        logic signed [15:0] exp_first [4];
        int rows [4];
        int seen, dones, bad;
        rows = '{30, 31, 0, 1};
        exp_first = '{16'sd448, 16'sd480, -16'sd512, -16'sd480};
        seen = 0;
        dones = 0;
        bad = 0;
        i_ready = 1'b1;
        start_fetch(30, 4);
        for (int c = 0; c < 170; c++) begin
            if (o_valid) begin
                if (seen < 4) begin
                    if (o_row[0] !== exp_first[seen] || o_row[31] !== exp_elem(rows[seen], 31)) begin
                        bad++;
                        $display("[TB] FAIL wrap_row%0d: got %0d %0d want %0d %0d", seen,
                                 o_row[0], o_row[31], exp_first[seen], exp_elem(rows[seen], 31));
                    end
                end
                seen++;
            end
            if (o_done) begin
                dones++;
                if (seen != 4) bad++;
            end
            tick();
        end
        checks++;
        if (bad != 0) failures++;
        checks++;
        if (seen != 4 || dones != 1 || o_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wrap_count: rows=%0d dones=%0d busy=%b want 4 1 0", seen, dones, o_busy);
        end
    endtask

    task automatic test_illegal_starts();
        int nums [2];
        nums = '{0, 33};
        for (int t = 0; t < 2; t++) begin
            start_fetch(0, nums[t]);
            checks++;
            if (o_err !== 1'b1 || o_busy !== 1'b0 || o_bram_en !== 1'b0) begin
                failures++;
                $display("[TB] FAIL illegal_%0d: err=%b busy=%b en=%b want 1 0 0",
                         nums[t], o_err, o_busy, o_bram_en);
            end
            tick();
            checks++;
            if (o_err !== 1'b0 || o_busy !== 1'b0 || o_bram_en !== 1'b0) begin
                failures++;
                $display("[TB] FAIL illegal_%0d_after: err=%b busy=%b en=%b want 0 0 0",
                         nums[t], o_err, o_busy, o_bram_en);
            end
        end
    endtask

    task automatic test_ignore_and_reset();
        int bad;
        i_ready = 1'b0;
        start_fetch(3, 1);
        while (cyc < 4) tick();
        i_start = 1'b1;
        i_row_idx = 5'd10;
        i_num_rows = 6'd0;
        tick();
        i_start = 1'b0;
        checks++;
        if (o_bram_addr !== 10'd100 || o_err !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ignore_start: addr=%0d err=%b busy=%b want 100 0 1", o_bram_addr, o_err, o_busy);
        end
        while (cyc < 10) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 32; k++) if (o_row[k] !== 16'sd0) bad++;
        checks++;
        if ({o_busy, o_err, o_valid, o_done, o_bram_en} !== 5'b0 || o_bram_addr !== 10'd0 || bad != 0) begin
            failures++;
            $display("[TB] FAIL midreset: flags=%b addr=%0d nonzero=%0d want 00000 0 0",
                     {o_busy, o_err, o_valid, o_done, o_bram_en}, o_bram_addr, bad);
        end
        tick();
        i_ready = 1'b1;
        start_fetch(5, 1);
        wait_valid();
        bad = 0;
        for (int k = 0; k < 32; k++) if (o_row[k] !== exp_elem(5, k)) bad++;
        checks++;
        if (cyc != 34 || o_row[0] !== -16'sd352 || bad != 0) begin
            failures++;
            $display("[TB] FAIL after_reset: cyc=%0d row0=%0d wrong=%0d want 34 -352 0", cyc, o_row[0], bad);
        end
        tick();
        tick();
    endtask

    task automatic test_rd_lat2();
        int bad;
        i2_ready = 1'b1;
        i2_start = 1'b1;
        i2_row_idx = 5'd0;
        i2_num_rows = 6'd1;
        cyc = 0;
        tick();
        i2_start = 1'b0;
        while (!o2_valid && cyc < 200) tick();
        checks++;
        if (cyc != 35) begin
            failures++;
            $display("[TB] FAIL lat2_cycle: got %0d want 35", cyc);
        end
        bad = 0;
        for (int k = 0; k < 32; k++) if (o2_row[k] !== exp_elem(0, k)) bad++;
        checks++;
        if (bad != 0 || o2_row[31] !== -16'sd481) begin
            failures++;
            $display("[TB] FAIL lat2_row: wrong=%0d row31=%0d want 0 -481", bad, o2_row[31]);
        end
        tick();
        checks++;
        if (o2_done !== 1'b1 || o2_busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL lat2_done: done=%b busy=%b want 1 0", o2_done, o2_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_backpressure();
        test_wrap_burst();
        test_illegal_starts();
        test_ignore_and_reset();
        test_rd_lat2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
